rpsc_power_sequencer: RTL and testbench

- Power-up/power-down sequencer for the RF tetrode power supply chain: anode PS, then G2 PS, then driver amplifier.
- Consumes the interlock/status outputs of the RPSC interlock card: alarm summaries, ground-hold OK, G2 OK, driver OK.
- Drives the PS enable commands.
- Enforces ordered ramp with per-stage timeouts, ordered shutdown, and latched fault handling.

---
 rtl/rpsc_power_sequencer_pkg.sv | 37 +++
 rtl/rpsc_power_sequencer_if.sv | 41 ++++
 rtl/rpsc_power_sequencer_timeout_counter.sv | 28 ++
 rtl/rpsc_power_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_rpsc_power_sequencer.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/rpsc_power_sequencer_pkg.sv
// rpsc_pkg: shared state/fault encodings and default timing for the RPSC
// power sequencer. Optional auto-restart is selected with RPSC_AUTO_RESTART_EN.
package rpsc_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_AN_UP   = 3'd1,
    S_G2_UP   = 3'd2,
    S_DR_UP   = 3'd3,
    S_RUN     = 3'd4,
    S_DR_DOWN = 3'd5,
    S_G2_DOWN = 3'd6,
    S_FAULT   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    F_NONE     = 3'd0,
    F_ALARM1   = 3'd1,
    F_ALARM2   = 3'd2,
    F_AN_TO    = 3'd3,
    F_G2_TO    = 3'd4,
    F_DR_TO    = 3'd5,
    F_RUN_LOSS = 3'd6
  } fault_t;

  localparam int DEF_T_AN         = 256;
  localparam int DEF_T_G2         = 512;
  localparam int DEF_T_DR         = 128;
  localparam int DEF_T_OFF        = 64;
  localparam int DEF_MAX_RETRY    = 3;
  localparam int DEF_RESTART_HOLD = 1024;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rpsc_power_sequencer_if.sv
// Operator/interlock-card side signals of the RPSC power sequencer.
// master drives the requests and card status, slave is the sequencer.
// retry_cnt exists only when RPSC_AUTO_RESTART_EN is defined.
interface rpsc_power_sequencer_if;

  logic       start;
  logic       stop;
  logic       fault_clr;
  logic       alarm1_n;
  logic       alarm2_n;
  logic       an_ok;
  logic       g2_ok;
  logic       dr_ok;
  logic       an_ps_on;
  logic       g2_ps_on;
  logic       dr_amp_on;
  logic       running;
  logic       fault;
  logic [2:0] fault_code;
  logic [2:0] state;
`ifdef RPSC_AUTO_RESTART_EN
  logic [1:0] retry_cnt;
`endif

  modport master (
    output start, stop, fault_clr, alarm1_n, alarm2_n, an_ok, g2_ok, dr_ok,
    input  an_ps_on, g2_ps_on, dr_amp_on, running, fault, fault_code, state
`ifdef RPSC_AUTO_RESTART_EN
    , input retry_cnt
`endif
  );

  modport slave (
    input  start, stop, fault_clr, alarm1_n, alarm2_n, an_ok, g2_ok, dr_ok,
    output an_ps_on, g2_ps_on, dr_amp_on, running, fault, fault_code, state
`ifdef RPSC_AUTO_RESTART_EN
    , output retry_cnt
`endif
  );

endinterface

// File: rtl/rpsc_power_sequencer_timeout_counter.sv
// rpsc_timeout_counter: per-state dwell/timeout counter. Cleared on every
// state entry, counts up while enabled and sticks at all-ones so a long
// wait can never wrap back into a false "not yet expired".
module rpsc_timeout_counter #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  input  logic [CW-1:0] term,
  output logic          done
);

  logic [CW-1:0] count;

  // Saturating up-counter with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + CW'(1);
    end
  end

  assign done = (count >= term);

endmodule

// File: rtl/rpsc_power_sequencer.sv
// rpsc_power_sequencer: ordered power-up/power-down of anode PS, G2 PS and
// driver amplifier with per-stage timeouts and a latched first-fault code.
// Define RPSC_AUTO_RESTART_EN to allow automatic retries after non-alarm faults.
module rpsc_power_sequencer
  import rpsc_pkg::*;
#(
  parameter int T_AN  = DEF_T_AN,
  parameter int T_G2  = DEF_T_G2,
  parameter int T_DR  = DEF_T_DR,
  parameter int T_OFF = DEF_T_OFF
`ifdef RPSC_AUTO_RESTART_EN
  , parameter int MAX_RETRY    = DEF_MAX_RETRY,
  parameter int RESTART_HOLD = DEF_RESTART_HOLD
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  rpsc_power_sequencer_if.slave bus
);

`ifdef RPSC_AUTO_RESTART_EN
  localparam int T_MAX = max2(max2(max2(T_AN, T_G2), max2(T_DR, T_OFF)), RESTART_HOLD);
`else
  localparam int T_MAX = max2(max2(T_AN, T_G2), max2(T_DR, T_OFF));
`endif
  localparam int CW = $clog2(T_MAX) + 1;

  state_t        state_q, state_d;
  fault_t        code_q, new_code, alarm_code;
  logic          alarm;
  logic [CW-1:0] term;
  logic          cnt_done;
  logic          an_q, g2_q, dr_q, run_q, fault_q;
`ifdef RPSC_AUTO_RESTART_EN
  logic [1:0]    retry_q;
  logic          restart;
`endif

  rpsc_timeout_counter #(.CW(CW)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_d != state_q),
    .enable (state_q != S_IDLE),
    .term   (term),
    .done   (cnt_done)
  );

  // Next-state selection: alarm beats timeout/run-loss, which beats stop, which beats progress.
  always_comb begin
    alarm      = !bus.alarm1_n || !bus.alarm2_n;
    alarm_code = !bus.alarm1_n ? F_ALARM1 : F_ALARM2;
    state_d    = state_q;
    new_code   = F_NONE;
    term       = '1;
`ifdef RPSC_AUTO_RESTART_EN
    restart    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.stop && !alarm) state_d = S_AN_UP;
      end
      S_AN_UP: begin
        term = CW'(T_AN - 1);
        if (alarm) begin
          state_d = S_FAULT; new_code = alarm_code;
        end else if (!bus.an_ok && cnt_done) begin
          state_d = S_FAULT; new_code = F_AN_TO;
        end else if (bus.stop) begin
          state_d = S_IDLE;
        end else if (bus.an_ok) begin
          state_d = S_G2_UP;
        end
      end
      S_G2_UP: begin
        term = CW'(T_G2 - 1);
        if (alarm) begin
          state_d = S_FAULT; new_code = alarm_code;
        end else if (!bus.g2_ok && cnt_done) begin
          state_d = S_FAULT; new_code = F_G2_TO;
        end else if (bus.stop) begin
          state_d = S_G2_DOWN;
        end else if (bus.g2_ok) begin
          state_d = S_DR_UP;
        end
      end
      S_DR_UP: begin
        term = CW'(T_DR - 1);
        if (alarm) begin
          state_d = S_FAULT; new_code = alarm_code;
        end else if (!bus.dr_ok && cnt_done) begin
          state_d = S_FAULT; new_code = F_DR_TO;
        end else if (bus.stop) begin
          state_d = S_DR_DOWN;
        end else if (bus.dr_ok) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (alarm) begin
          state_d = S_FAULT; new_code = alarm_code;
        end else if (!(bus.an_ok && bus.g2_ok && bus.dr_ok)) begin
          state_d = S_FAULT; new_code = F_RUN_LOSS;
        end else if (bus.stop) begin
          state_d = S_DR_DOWN;
        end
      end
      S_DR_DOWN: begin
        term = CW'(T_OFF - 1);
        if (alarm) begin
          state_d = S_FAULT; new_code = alarm_code;
        end else if (cnt_done) begin
          state_d = S_G2_DOWN;
        end
      end
      S_G2_DOWN: begin
        term = CW'(T_OFF - 1);
        if (alarm) begin
          state_d = S_FAULT; new_code = alarm_code;
        end else if (cnt_done) begin
          state_d = S_IDLE;
        end
      end
      S_FAULT: begin
`ifdef RPSC_AUTO_RESTART_EN
        term = CW'(RESTART_HOLD - 1);
`endif
        if (bus.fault_clr && !bus.start && !alarm) begin
          state_d = S_IDLE;
        end
`ifdef RPSC_AUTO_RESTART_EN
        else if ((code_q inside {F_AN_TO, F_G2_TO, F_DR_TO, F_RUN_LOSS}) && !alarm &&
                 (int'(retry_q) < MAX_RETRY) && cnt_done) begin
          state_d = S_AN_UP;
          restart = 1'b1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, latched fault code and enables are all registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      code_q  <= F_NONE;
      an_q    <= 1'b0;
      g2_q    <= 1'b0;
      dr_q    <= 1'b0;
      run_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != S_FAULT) begin
        code_q <= F_NONE;
      end else if (state_q != S_FAULT) begin
        code_q <= new_code;
      end
      an_q    <= state_d inside {S_AN_UP, S_G2_UP, S_DR_UP, S_RUN, S_DR_DOWN, S_G2_DOWN};
      g2_q    <= state_d inside {S_G2_UP, S_DR_UP, S_RUN, S_DR_DOWN};
      dr_q    <= state_d inside {S_DR_UP, S_RUN};
      run_q   <= (state_d == S_RUN);
      fault_q <= (state_d == S_FAULT);
    end
  end

`ifdef RPSC_AUTO_RESTART_EN
  // Retry budget: operator stop/clear refills it, each automatic restart consumes one.
  always_ff @(posedge clk) begin
    if (reset || bus.fault_clr || bus.stop) begin
      retry_q <= 2'd0;
    end else if (restart) begin
      retry_q <= retry_q + 2'd1;
    end
  end

  assign bus.retry_cnt = retry_q;
`endif

  assign bus.state      = state_q;
  assign bus.fault_code = code_q;
  assign bus.an_ps_on   = an_q;
  assign bus.g2_ps_on   = g2_q;
  assign bus.dr_amp_on  = dr_q;
  assign bus.running    = run_q;
  assign bus.fault      = fault_q;

endmodule

// File: tb/tb_rpsc_power_sequencer.sv
// Self-checking bench for rpsc_power_sequencer: directed scenarios with
// hand-computed expectations plus randomized traffic, all compared every
// cycle against a rule-level model. Honours RPSC_AUTO_RESTART_EN.
module tb_rpsc_power_sequencer;

  localparam int T_AN  = 10;
  localparam int T_G2  = 20;
  localparam int T_DR  = 8;
  localparam int T_OFF = 4;
  localparam int MAX_RETRY    = 3;
  localparam int RESTART_HOLD = 16;

  logic clk = 1'b0;
  logic reset;
  bit   check_en = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  rpsc_power_sequencer_if bus ();

  rpsc_power_sequencer #(
    .T_AN(T_AN), .T_G2(T_G2), .T_DR(T_DR), .T_OFF(T_OFF)
`ifdef RPSC_AUTO_RESTART_EN
    , .MAX_RETRY(MAX_RETRY), .RESTART_HOLD(RESTART_HOLD)
`endif
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model tables taken from the state/enable/fault definitions
  int en_an [8] = '{0, 1, 1, 1, 1, 1, 1, 0};
  int en_g2 [8] = '{0, 0, 1, 1, 1, 1, 0, 0};
  int en_dr [8] = '{0, 0, 0, 1, 1, 0, 0, 0};
  int ramp_lim  [4] = '{0, T_AN, T_G2, T_DR};
  int ramp_code [4] = '{0, 3, 4, 5};
  int stop_dest [4] = '{0, 0, 6, 5};

  int m_st = 0, m_age = 0, m_code = 0, m_retry = 0;

  // Behavioural reference: apply the sequencing rules to the inputs seen at each edge
  always @(posedge clk) begin : model
    int  nxt, ncode;
    int  ok_v [4];
    bit  alarm, restarted;
    if (reset) begin
      m_st = 0; m_age = 0; m_code = 0; m_retry = 0;
    end else begin
      ok_v[0] = 0;
      ok_v[1] = int'(bus.an_ok);
      ok_v[2] = int'(bus.g2_ok);
      ok_v[3] = int'(bus.dr_ok);
      alarm = !bus.alarm1_n || !bus.alarm2_n;
      nxt = m_st; ncode = 0; restarted = 1'b0;
      if (m_st == 0) begin
        if (bus.start && !bus.stop && !alarm) nxt = 1;
      end else if (m_st == 7) begin
        if (bus.fault_clr && !bus.start && !alarm) nxt = 0;
`ifdef RPSC_AUTO_RESTART_EN
        else if (m_code >= 3 && !alarm && m_retry < MAX_RETRY && m_age >= RESTART_HOLD - 1) begin
          nxt = 1; restarted = 1'b1;
        end
`endif
      end else if (alarm) begin
        nxt = 7; ncode = !bus.alarm1_n ? 1 : 2;
      end else if (m_st <= 3) begin
        if (ok_v[m_st] == 0 && m_age == ramp_lim[m_st] - 1) begin
          nxt = 7; ncode = ramp_code[m_st];
        end else if (bus.stop) nxt = stop_dest[m_st];
        else if (ok_v[m_st] != 0) nxt = m_st + 1;
      end else if (m_st == 4) begin
        if (!(bus.an_ok && bus.g2_ok && bus.dr_ok)) begin
          nxt = 7; ncode = 6;
        end else if (bus.stop) nxt = 5;
      end else if (m_age == T_OFF - 1) begin
        nxt = (m_st == 5) ? 6 : 0;
      end
      if (bus.fault_clr || bus.stop) m_retry = 0;
      else if (restarted) m_retry = m_retry + 1;
      if (nxt != 7) m_code = 0;
      else if (m_st != 7) m_code = ncode;
      m_age = (nxt != m_st) ? 0 : m_age + 1;
      m_st = nxt;
    end
  end

  task automatic checkOutput();
    int got_v, exp_v;
    got_v = {bus.state, bus.an_ps_on, bus.g2_ps_on, bus.dr_amp_on, bus.running, bus.fault, bus.fault_code};
    exp_v = {m_st[2:0], en_an[m_st][0], en_g2[m_st][0], en_dr[m_st][0],
             m_st == 4, m_st == 7, m_code[2:0]};
`ifdef RPSC_AUTO_RESTART_EN
    got_v = {got_v, bus.retry_cnt};
    exp_v = {exp_v, m_retry[1:0]};
`endif
    n_total++;
    if (got_v === exp_v) n_pass++;
    else $display("[TB] FAIL cycle_outputs t=%0t: got state/an/g2/dr/run/fault/code(/retry)=%h required %h",
                  $time, got_v, exp_v);
  endtask

  // Compare DUT against the model on every falling edge once reset has been applied
  always @(negedge clk) begin
    if (check_en) checkOutput();
  end

  task automatic expectEq(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("[TB] FAIL %s: got %0d required %0d", name, act, exp);
  endtask

  task automatic applyStimulus(input bit st, input bit sp, input bit clr, input bit a1,
                               input bit a2, input bit an, input bit g2, input bit dr);
    bus.start = st; bus.stop = sp; bus.fault_clr = clr;
    bus.alarm1_n = a1; bus.alarm2_n = a2;
    bus.an_ok = an; bus.g2_ok = g2; bus.dr_ok = dr;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int p_tab [4] = '{0, 70, 97, 100};
    int p_ok;
    reset = 1'b1;
    applyStimulus(0, 0, 0, 1, 1, 0, 0, 0);
    tick(2);
    check_en = 1'b1;
    expectEq("reset_state", int'(bus.state), 0);
    expectEq("reset_enables", int'({bus.an_ps_on, bus.g2_ps_on, bus.dr_amp_on}), 0);
    expectEq("reset_code", int'(bus.fault_code), 0);
    reset = 1'b0;

    // Normal power-up
    applyStimulus(1, 0, 0, 1, 1, 0, 0, 0);
    tick(1);
    expectEq("up_an_state", int'(bus.state), 1);
    expectEq("up_an_en", int'({bus.an_ps_on, bus.g2_ps_on, bus.dr_amp_on}), 3'b100);
    applyStimulus(0, 0, 0, 1, 1, 0, 0, 0);
    tick(2); bus.an_ok = 1'b1; tick(1);
    expectEq("up_g2_state", int'(bus.state), 2);
    expectEq("up_g2_en", int'({bus.an_ps_on, bus.g2_ps_on, bus.dr_amp_on}), 3'b110);
    tick(4); bus.g2_ok = 1'b1; tick(1);
    expectEq("up_dr_state", int'(bus.state), 3);
    tick(1); bus.dr_ok = 1'b1; tick(1);
    expectEq("up_run_state", int'(bus.state), 4);
    expectEq("up_running", int'(bus.running), 1);

    // Orderly stop from RUN
    bus.stop = 1'b1; tick(1); bus.stop = 1'b0;
    expectEq("stop_dr_off", int'({bus.an_ps_on, bus.g2_ps_on, bus.dr_amp_on}), 3'b110);
    tick(3);
    expectEq("stop_g2_still_on", int'(bus.g2_ps_on), 1);
    tick(1);
    expectEq("stop_g2_off", int'({bus.state, bus.g2_ps_on}), {3'd6, 1'b0});
    tick(3);
    expectEq("stop_an_still_on", int'(bus.an_ps_on), 1);
    tick(1);
    expectEq("stop_idle", int'({bus.state, bus.an_ps_on}), {3'd0, 1'b0});

    // Anode timeout then clear
    applyStimulus(1, 0, 0, 1, 1, 0, 0, 0);
    tick(1); bus.start = 1'b0;
    tick(9);
    expectEq("to_before", int'(bus.state), 1);
    tick(1);
    expectEq("to_state", int'(bus.state), 7);
    expectEq("to_code", int'(bus.fault_code), 3);
    expectEq("to_enables", int'({bus.an_ps_on, bus.g2_ps_on, bus.dr_amp_on}), 0);
    bus.fault_clr = 1'b1; tick(1); bus.fault_clr = 1'b0;
    expectEq("to_cleared", int'({bus.state, bus.fault_code}), 0);

    // Run-time alarm on section 2
    applyStimulus(1, 0, 0, 1, 1, 1, 1, 1);
    tick(1); bus.start = 1'b0; tick(3);
    expectEq("alm_in_run", int'(bus.state), 4);
    bus.alarm2_n = 1'b0; tick(1); bus.alarm2_n = 1'b1;
    expectEq("alm_state", int'(bus.state), 7);
    expectEq("alm_code", int'(bus.fault_code), 2);
    expectEq("alm_enables", int'({bus.an_ps_on, bus.g2_ps_on, bus.dr_amp_on}), 0);
    tick(2);
    expectEq("alm_code_hold", int'(bus.fault_code), 2);
    bus.fault_clr = 1'b1; tick(1); bus.fault_clr = 1'b0;

    // Alarm1 together with stop in DR_UP, then start+stop in IDLE
    applyStimulus(1, 0, 0, 1, 1, 1, 1, 0);
    tick(1); bus.start = 1'b0; tick(2);
    expectEq("sim_in_dr_up", int'(bus.state), 3);
    bus.alarm1_n = 1'b0; bus.stop = 1'b1; tick(1);
    expectEq("sim_alarm1", int'({bus.state, bus.fault_code}), {3'd7, 3'd1});
    applyStimulus(0, 0, 1, 1, 1, 0, 0, 0); tick(1);
    applyStimulus(1, 1, 0, 1, 1, 0, 0, 0); tick(2);
    expectEq("sim_start_stop", int'(bus.state), 0);

    // Synchronous reset in G2_UP
    applyStimulus(1, 0, 0, 1, 1, 1, 0, 0);
    tick(1); bus.start = 1'b0; tick(1);
    expectEq("rst_in_g2", int'(bus.state), 2);
    reset = 1'b1; tick(1); reset = 1'b0;
    expectEq("rst_state", int'(bus.state), 0);
    expectEq("rst_enables", int'({bus.an_ps_on, bus.g2_ps_on, bus.dr_amp_on}), 0);

`ifdef RPSC_AUTO_RESTART_EN
    // Three RUN_LOSS retries, the fourth fault stays latched
    applyStimulus(1, 0, 0, 1, 1, 1, 1, 1);
    tick(1); bus.start = 1'b0; tick(3);
    for (int i = 0; i < 4; i++) begin
      bus.dr_ok = 1'b0; tick(1); bus.dr_ok = 1'b1;
      expectEq("rr_code", int'(bus.fault_code), 6);
      tick(20);
      expectEq("rr_state", int'(bus.state), (i < 3) ? 4 : 7);
      expectEq("rr_count", int'(bus.retry_cnt), (i < 3) ? i + 1 : 3);
    end
    bus.fault_clr = 1'b1; tick(1); bus.fault_clr = 1'b0;
`endif

    // Randomized traffic, ok-probability varied per segment
    for (int seg = 0; seg < 40; seg++) begin
      p_ok = p_tab[$urandom_range(3, 0)];
      repeat (50) begin
        applyStimulus($urandom_range(99, 0) < 60, $urandom_range(99, 0) < 4,
                      $urandom_range(99, 0) < 8, $urandom_range(99, 0) >= 1,
                      $urandom_range(99, 0) >= 1, $urandom_range(99, 0) < p_ok,
                      $urandom_range(99, 0) < p_ok, $urandom_range(99, 0) < p_ok);
        tick(1);
      end
    end

    reset = 1'b1; tick(2);
    $display("[TB] %0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
